vga_timing: RTL and testbench

- Free-running VGA raster timing generator. It drives hcount/vcount, sync and blanking into the game control top, which feeds the background stage first.
- Produces one frame-start strobe and a frame counter for once-per-frame game logic such as ball and paddle updates.
- Default timing is SVGA 800x600@60 with a 40 MHz pixel clock and positive sync polarity.

---
 rtl/vga_timing_if.sv | 43 ++++
 rtl/vga_timing.sv | 112 +++++++++++
 tb/tb_vga_timing.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// Raster output bundle of vga_timing; the pixel enable is only present when
// VGA_TIMING_CE_EN is defined.
interface vga_timing_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        frame_start;
    logic [7:0]  frame_cnt;
`ifdef VGA_TIMING_CE_EN
    logic        pix_ce;
`endif

    modport master (
`ifdef VGA_TIMING_CE_EN
        input  pix_ce,
`endif
        output hcount,
        output vcount,
        output hsync,
        output vsync,
        output hblnk,
        output vblnk,
        output frame_start,
        output frame_cnt
    );

    modport slave (
`ifdef VGA_TIMING_CE_EN
        output pix_ce,
`endif
        input  hcount,
        input  vcount,
        input  hsync,
        input  vsync,
        input  hblnk,
        input  vblnk,
        input  frame_start,
        input  frame_cnt
    );
endinterface

// File: rtl/vga_timing.sv
// Free-running VGA raster timing generator with frame strobe and frame counter.
// Optional macro VGA_TIMING_CE_EN adds a pixel clock enable (pix_ce).
module vga_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int SYNC_POL = 1
) (
    input  logic         pclk,
    input  logic         rst,
    vga_timing_if.master vif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST    = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic        SYNC_ON    = (SYNC_POL != 0);

    logic        advance;

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_start_q, frame_start_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    always_comb begin
`ifdef VGA_TIMING_CE_EN
        advance = vif.pix_ce;
`else
        advance = 1'b1;
`endif
    end

    always_comb begin
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = 1'b0;
        if (advance) begin
            if (hcount_q == H_LAST) begin
                hcount_d = '0;
                if (vcount_q == V_LAST) begin
                    vcount_d      = '0;
                    frame_start_d = 1'b1;
                    frame_cnt_d   = frame_cnt_q + 8'd1;
                end else begin
                    vcount_d = vcount_q + 11'd1;
                end
            end else begin
                hcount_d = hcount_q + 11'd1;
            end
        end
    end

    // Decoding the next-state counters keeps every registered output aligned
    // with hcount/vcount; vsync follows vcount and so only moves at hcount 0.
    always_comb begin
        hblnk_d = (hcount_d >= H_ACT_END);
        vblnk_d = (vcount_d >= V_ACT_END);
        hsync_d = ((hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST)) ? SYNC_ON : ~SYNC_ON;
        vsync_d = ((vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST)) ? SYNC_ON : ~SYNC_ON;
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign vif.hcount      = hcount_q;
    assign vif.vcount      = vcount_q;
    assign vif.hsync       = hsync_q;
    assign vif.vsync       = vsync_q;
    assign vif.hblnk       = hblnk_q;
    assign vif.vblnk       = vblnk_q;
    assign vif.frame_start = frame_start_q;
    assign vif.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default SVGA instance and a shrunken, inverted-sync
// instance checked every cycle against an advance-count raster model.
module tb_vga_timing;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit pol;
    } cfg_t;

`ifdef VGA_TIMING_CE_EN
    localparam bit CE_PRESENT = 1'b1;
`else
    localparam bit CE_PRESENT = 1'b0;
`endif

    localparam longint BIG_FRAME   = 64'd1056 * 64'd628;
    localparam longint SMALL_FRAME = 64'd14 * 64'd7;

    logic   pclk = 1'b0;
    logic   rst  = 1'b0;
`ifdef VGA_TIMING_CE_EN
    logic   pix_ce = 1'b1;
`endif

    int     checks = 0;
    int     errors = 0;

    cfg_t   big_cfg;
    cfg_t   small_cfg;
    longint t_big   = 0;
    longint t_small = 0;
    bit     fs_big   = 1'b0;
    bit     fs_small = 1'b0;
    bit     ce_phase = 1'b0;

    vga_timing_if big_if ();
    vga_timing_if small_if ();

`ifdef VGA_TIMING_CE_EN
    assign big_if.pix_ce   = pix_ce;
    assign small_if.pix_ce = pix_ce;
`endif

    vga_timing u_big (
        .pclk (pclk),
        .rst  (rst),
        .vif  (big_if)
    );

    vga_timing #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (0)
    ) u_small (
        .pclk (pclk),
        .rst  (rst),
        .vif  (small_if)
    );

    always #5 pclk = ~pclk;

    // The raster is a pure function of how many advances happened since reset.
    task automatic checkOutput(input string tag, input cfg_t c, input longint t, input bit fs_exp,
                               input logic [10:0] hc, input logic [10:0] vc,
                               input logic hs, input logic vs, input logic hb, input logic vb,
                               input logic fs, input logic [7:0] fc);
        int htot, vtot, eh, ev, ef;
        logic ehs, evs, ehb, evb;
        htot = c.ha + c.hf + c.hs + c.hb;
        vtot = c.va + c.vf + c.vs + c.vb;
        eh   = int'(t % longint'(htot));
        ev   = int'((t / longint'(htot)) % longint'(vtot));
        ef   = int'((t / (longint'(htot) * longint'(vtot))) % 256);
        ehb  = (eh >= c.ha);
        evb  = (ev >= c.va);
        ehs  = (eh >= c.ha + c.hf && eh <= c.ha + c.hf + c.hs - 1) ? c.pol : !c.pol;
        evs  = (ev >= c.va + c.vf && ev <= c.va + c.vf + c.vs - 1) ? c.pol : !c.pol;

        checks++;
        assert (hc === 11'(eh)) else begin errors++; $error("[TB] FAIL %s hcount got %0d want %0d", tag, hc, eh); end
        checks++;
        assert (vc === 11'(ev)) else begin errors++; $error("[TB] FAIL %s vcount got %0d want %0d", tag, vc, ev); end
        checks++;
        assert (hs === ehs) else begin errors++; $error("[TB] FAIL %s hsync got %0b want %0b (h=%0d)", tag, hs, ehs, eh); end
        checks++;
        assert (vs === evs) else begin errors++; $error("[TB] FAIL %s vsync got %0b want %0b (v=%0d)", tag, vs, evs, ev); end
        checks++;
        assert (hb === ehb) else begin errors++; $error("[TB] FAIL %s hblnk got %0b want %0b (h=%0d)", tag, hb, ehb, eh); end
        checks++;
        assert (vb === evb) else begin errors++; $error("[TB] FAIL %s vblnk got %0b want %0b (v=%0d)", tag, vb, evb, ev); end
        checks++;
        assert (fs === fs_exp) else begin errors++; $error("[TB] FAIL %s frame_start got %0b want %0b (t=%0d)", tag, fs, fs_exp, t); end
        checks++;
        assert (fc === 8'(ef)) else begin errors++; $error("[TB] FAIL %s frame_cnt got %0d want %0d", tag, fc, ef); end
    endtask

    task automatic checkBoth(input string tag);
        checkOutput({tag, "/big"}, big_cfg, t_big, fs_big,
                    big_if.hcount, big_if.vcount, big_if.hsync, big_if.vsync,
                    big_if.hblnk, big_if.vblnk, big_if.frame_start, big_if.frame_cnt);
        checkOutput({tag, "/small"}, small_cfg, t_small, fs_small,
                    small_if.hcount, small_if.vcount, small_if.hsync, small_if.vsync,
                    small_if.hblnk, small_if.vblnk, small_if.frame_start, small_if.frame_cnt);
    endtask

    // mode 0: always enabled, 1: every other cycle, 2: random enable.
    function automatic bit pickCe(input int mode);
        bit ce;
        case (mode)
            1:       begin ce_phase = ~ce_phase; ce = ce_phase; end
            2:       ce = 1'($urandom_range(0, 1));
            default: ce = 1'b1;
        endcase
        return ce || !CE_PRESENT;
    endfunction

    // Called at a negedge: drive, let one posedge happen, update model, check.
    task automatic applyStimulus(input bit ce);
`ifdef VGA_TIMING_CE_EN
        pix_ce = ce;
`endif
        @(posedge pclk);
        if (!rst) begin
            t_big = 0; t_small = 0; fs_big = 1'b0; fs_small = 1'b0;
        end else if (ce) begin
            t_big++;
            t_small++;
            fs_big   = (t_big % BIG_FRAME) == 0;
            fs_small = (t_small % SMALL_FRAME) == 0;
        end else begin
            fs_big = 1'b0; fs_small = 1'b0;
        end
        @(negedge pclk);
        checkBoth("step");
    endtask

    task automatic asyncReset(input string tag);
        #($urandom_range(1, 3));
        rst = 1'b0;
        t_big = 0; t_small = 0; fs_big = 1'b0; fs_small = 1'b0;
        #1;
        checkBoth(tag);
        @(negedge pclk);
        applyStimulus(1'b1);
        applyStimulus(1'b1);
        rst = 1'b1;
    endtask

    initial begin
        int n;
        big_cfg   = '{ha: 800, hf: 40, hs: 128, hb: 88, va: 600, vf: 1, vs: 4, vb: 23, pol: 1'b1};
        small_cfg = '{ha: 8, hf: 2, hs: 2, hb: 2, va: 4, vf: 1, vs: 1, vb: 1, pol: 1'b0};

        @(negedge pclk);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1);
        $display("[TB] reset state checked, releasing reset");
        rst = 1'b1;

        for (int i = 0; i < 2 * 1056 + 20; i++) applyStimulus(pickCe(0));

        n = 0;
        while ((t_big % 1056) != 500 && n < 2200) begin
            applyStimulus(pickCe(0));
            n++;
        end
        checks++;
        assert ((t_big % 1056) == 500) else begin errors++; $error("[TB] FAIL reach_h500 got %0d want 500", t_big % 1056); end
        asyncReset("midline_reset");
        $display("[TB] mid-line reset done, running small raster past frame_cnt wrap");

        n = 0;
        while (t_small < SMALL_FRAME * 257 + 5 && n < 80000) begin
            applyStimulus(pickCe(2));
            n++;
        end
        checks++;
        assert (t_small >= SMALL_FRAME * 257 + 5) else begin errors++; $error("[TB] FAIL wrap_budget got %0d want %0d", t_small, SMALL_FRAME * 257 + 5); end

        for (int i = 0; i < 2200; i++) applyStimulus(pickCe(1));

        n = int'($urandom_range(10, 400));
        for (int i = 0; i < n; i++) applyStimulus(pickCe(2));
        asyncReset("random_reset");
        for (int i = 0; i < 200; i++) applyStimulus(pickCe(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
